// File: rtl/ddr_burst_pkg.sv
// Shared definitions for the DDR-style burst interface: bus widths, beat
// types and the responder state encoding, used by responder and initiator.
`timescale 1ns/1ps

package ddr_burst_pkg;

  // Burst interface widths.
  localparam int ADDR_W = 25;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] burst_addr_t;
  typedef logic [LEN_W-1:0]  burst_len_t;
  typedef logic [DATA_W-1:0] burst_data_t;

  // Responder protocol states.
  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    WR_DATA = 3'd2,
    WR_DONE = 3'd3,
    RD_WAIT = 3'd4,
    RD_DATA = 3'd5,
    RD_DONE = 3'd6
  } burst_state_t;

  // True when a request carries no data beats.
  function automatic logic burst_is_empty(input burst_len_t len);
    return (len == '0);
  endfunction

endpackage

// File: rtl/burst_sp_ram.sv
// Single-port 32-bit RAM with registered read (one cycle latency).
// No reset on the array or the read register so it maps onto block RAM.
`timescale 1ns/1ps

module burst_sp_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write when enabled; the addressed word is read out every cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_ram_responder.sv
// Burst responder backed by an internal RAM. After a fixed init delay it
// serves write and read bursts one at a time (write has priority), wrapping
// addresses inside the RAM and pulsing a finish strobe per burst.
`timescale 1ns/1ps

module burst_ram_responder
  import ddr_burst_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int INIT_CYCLES = 16,
  parameter int RD_LATENCY  = 2
) (
  input  logic              phy_clk,
  input  logic              rst_n,
  output logic              local_init_done,
  input  logic              wr_burst_req,
  input  logic [ADDR_W-1:0] wr_burst_addr,
  input  logic [LEN_W-1:0]  wr_burst_len,
  output logic              wr_burst_data_req,
  input  logic [DATA_W-1:0] wr_burst_data,
  output logic              wr_burst_finish,
  input  logic              rd_burst_req,
  input  logic [ADDR_W-1:0] rd_burst_addr,
  input  logic [LEN_W-1:0]  rd_burst_len,
  output logic              rd_burst_data_valid,
  output logic [DATA_W-1:0] rd_burst_data,
  output logic              rd_burst_finish
);

  localparam int INIT_CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_CW = 3;

  burst_state_t       state_q, state_d;
  logic [INIT_CW-1:0] init_cnt_q, init_cnt_d;
  logic               init_done_q, init_done_d;
  logic [MEM_AW-1:0]  base_q, base_d;
  burst_len_t         len_q, len_d;
  burst_len_t         cnt_q, cnt_d;
  logic [WAIT_CW-1:0] wait_q, wait_d;
  logic               hold_q, hold_d;
  burst_data_t        rd_last_q;

  logic               ram_we;
  logic [MEM_AW-1:0]  ram_addr;
  burst_data_t        ram_rdata;

  // Upper request address bits fall outside the RAM and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_burst_addr[ADDR_W-1:MEM_AW], rd_burst_addr[ADDR_W-1:MEM_AW]};

  // RAM word for beat 'beat' of a burst starting at 'base'; wraps at the top.
  function automatic logic [MEM_AW-1:0] ram_index(input logic [MEM_AW-1:0] base,
                                                  input burst_len_t beat);
    return base + MEM_AW'(beat);
  endfunction

  // State register and burst bookkeeping; reset aborts any burst in flight.
  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state logic, handshake outputs and RAM port control.
  always_comb begin
    state_d             = state_q;
    init_cnt_d          = init_cnt_q;
    init_done_d         = init_done_q;
    base_d              = base_q;
    len_d               = len_q;
    cnt_d               = cnt_q;
    wait_d              = wait_q;
    hold_d              = 1'b0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    ram_we              = 1'b0;
    ram_addr            = base_q;

    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_CW'(INIT_CYCLES - 1)) begin
          init_done_d = 1'b1;
          init_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        cnt_d    = '0;
        wait_d   = '0;
        // Prefetch the first read word so RD_LATENCY = 1 still meets timing.
        ram_addr = rd_burst_addr[MEM_AW-1:0];
        // The first idle cycle after a finish gives the initiator time to drop req.
        if (!hold_q) begin
          if (wr_burst_req) begin
            base_d  = wr_burst_addr[MEM_AW-1:0];
            len_d   = wr_burst_len;
            state_d = burst_is_empty(wr_burst_len) ? WR_DONE : WR_DATA;
          end else if (rd_burst_req) begin
            base_d = rd_burst_addr[MEM_AW-1:0];
            len_d  = rd_burst_len;
            if (burst_is_empty(rd_burst_len)) begin
              state_d = RD_DONE;
            end else if (RD_LATENCY == 1) begin
              state_d = RD_DATA;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end

      WR_DATA: begin
        // cnt_q counts request cycles; beat cnt_q-1 is on the data bus now.
        wr_burst_data_req = (cnt_q != len_q);
        ram_we            = (cnt_q != '0);
        ram_addr          = ram_index(base_q, cnt_q - 1'b1);
        if (cnt_q == len_q) begin
          state_d = WR_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_DONE: begin
        wr_burst_finish = 1'b1;
        hold_d          = 1'b1;
        state_d         = IDLE;
      end

      RD_WAIT: begin
        ram_addr = base_q;
        if (wait_q == WAIT_CW'(RD_LATENCY - 2)) begin
          state_d = RD_DATA;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      RD_DATA: begin
        // RAM output holds beat cnt_q; fetch the next one behind it.
        rd_burst_data_valid = 1'b1;
        ram_addr            = ram_index(base_q, cnt_q + 1'b1);
        if (cnt_q == len_q - 1'b1) begin
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_DONE: begin
        rd_burst_finish = 1'b1;
        hold_d          = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Keep the last delivered read beat so the data bus is stable between beats.
  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last_q <= '0;
    end else if (rd_burst_data_valid) begin
      rd_last_q <= ram_rdata;
    end
  end

  assign rd_burst_data   = rd_burst_data_valid ? ram_rdata : rd_last_q;
  assign local_init_done = init_done_q;

  burst_sp_ram #(
    .AW (MEM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk_i   (phy_clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wr_burst_data),
    .rdata_o (ram_rdata)
  );

endmodule
